// File: rtl/hq2x_pkg.sv
// Shared types and neighbour-rotation tables for the hq2x blend sequencer.
// Tables hold one 4-bit 3x3 index per quadrant; quadrant 0 is in the low nibble.
package hq2x_pkg;

  localparam int PIX_W_DEF = 18;
  localparam int N_QUAD    = 4;
  localparam int IDX_E     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Neighbour indices are rotated so every quadrant sees the same local geometry.
  localparam logic [15:0] NB_A = {4'd8, 4'd6, 4'd2, 4'd0};
  localparam logic [15:0] NB_B = {4'd7, 4'd3, 4'd5, 4'd1};
  localparam logic [15:0] NB_D = {4'd5, 4'd7, 4'd1, 4'd3};
  localparam logic [15:0] NB_F = {4'd3, 4'd1, 4'd7, 4'd5};
  localparam logic [15:0] NB_H = {4'd1, 4'd5, 4'd3, 4'd7};

  localparam logic [1:0] SLOT_TL = 2'd0;
  localparam logic [1:0] SLOT_TR = 2'd1;
  localparam logic [1:0] SLOT_BL = 2'd2;
  localparam logic [1:0] SLOT_BR = 2'd3;

  function automatic logic [3:0] nb_idx(input logic [15:0] tbl, input logic [1:0] q);
    return tbl[4*q +: 4];
  endfunction

endpackage

// File: rtl/hq2x_quad_mux.sv
// Selects the A/B/D/F/H blend operands for quadrant i_q from a 3x3 neighbourhood.
// Purely combinational, no handshake.
module hq2x_quad_mux
  import hq2x_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic [9*PIX_W-1:0] i_nbr,
  input  logic [1:0]         i_q,
  output logic [PIX_W-1:0]   o_a,
  output logic [PIX_W-1:0]   o_b,
  output logic [PIX_W-1:0]   o_d,
  output logic [PIX_W-1:0]   o_f,
  output logic [PIX_W-1:0]   o_h
);

  function automatic logic [PIX_W-1:0] pick(input logic [9*PIX_W-1:0] nbr, input logic [3:0] idx);
    return nbr[PIX_W*idx +: PIX_W];
  endfunction

  always_comb begin
    o_a = pick(i_nbr, nb_idx(NB_A, i_q));
    o_b = pick(i_nbr, nb_idx(NB_B, i_q));
    o_d = pick(i_nbr, nb_idx(NB_D, i_q));
    o_f = pick(i_nbr, nb_idx(NB_F, i_q));
    o_h = pick(i_nbr, nb_idx(NB_H, i_q));
  end

endmodule

// File: rtl/hq2x_blend_sequencer.sv
// Runs one shared hq2x blend unit over the four quadrants of a pixel, out_valid 4*BLEND_LATENCY edges after accept.
// Accepts only in IDLE; the finished 2x2 block is held until out_ready, then in_ready returns next cycle.
module hq2x_blend_sequencer
  import hq2x_pkg::*;
#(
  parameter int BLEND_LATENCY = 1,
  parameter int PIX_W         = PIX_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [9*PIX_W-1:0]   in_pix,
  input  logic [23:0]          in_rule,
  input  logic                 cfg_disable,
  output logic [5:0]           blend_rule,
  output logic                 blend_disable,
  output logic [PIX_W-1:0]     blend_e,
  output logic [PIX_W-1:0]     blend_a,
  output logic [PIX_W-1:0]     blend_b,
  output logic [PIX_W-1:0]     blend_d,
  output logic [PIX_W-1:0]     blend_f,
  output logic [PIX_W-1:0]     blend_h,
  input  logic [PIX_W-1:0]     blend_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*PIX_W-1:0]   out_pix,
  output logic                 busy
);

  localparam int              WCW     = $clog2(BLEND_LATENCY + 1);
  localparam logic [WCW-1:0]  WC_LOAD = WCW'(BLEND_LATENCY);
  localparam logic [WCW-1:0]  WC_ONE  = WCW'(1);

  state_t               r_state;
  logic [1:0]           r_q;
  logic [WCW-1:0]       r_wcnt;
  logic [9*PIX_W-1:0]   r_pix;
  logic [23:0]          r_rule;
  logic                 r_in_ready, r_out_valid, r_busy;
  logic [5:0]           r_blend_rule;
  logic                 r_blend_disable;
  logic [PIX_W-1:0]     r_e, r_a, r_b, r_d, r_f, r_h;
  logic [4*PIX_W-1:0]   r_out_pix;

  logic [9*PIX_W-1:0]   w_src;
  logic [23:0]          w_rule_src;
  logic [1:0]           w_qn;
  logic [5:0]           w_rule_n;
  logic [PIX_W-1:0]     w_e, w_a, w_b, w_d, w_f, w_h;

  // In IDLE the next operands come straight from the input; afterwards from the latched copy.
  assign w_src      = (r_state == ST_IDLE) ? in_pix  : r_pix;
  assign w_rule_src = (r_state == ST_IDLE) ? in_rule : r_rule;
  assign w_qn       = (r_state == ST_IDLE) ? 2'd0    : r_q + 2'd1;
  assign w_rule_n   = w_rule_src[6*w_qn +: 6];
  assign w_e        = w_src[IDX_E*PIX_W +: PIX_W];

  hq2x_quad_mux #(.PIX_W(PIX_W)) u_quad_mux (
    .i_nbr (w_src),
    .i_q   (w_qn),
    .o_a   (w_a),
    .o_b   (w_b),
    .o_d   (w_d),
    .o_f   (w_f),
    .o_h   (w_h)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_q             <= 2'd0;
      r_wcnt          <= '0;
      r_pix           <= '0;
      r_rule          <= '0;
      r_in_ready      <= 1'b1;
      r_out_valid     <= 1'b0;
      r_busy          <= 1'b0;
      r_blend_rule    <= '0;
      r_blend_disable <= 1'b0;
      {r_e, r_a, r_b, r_d, r_f, r_h} <= '0;
      r_out_pix       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_pix           <= in_pix;
            r_rule          <= in_rule;
            r_blend_disable <= cfg_disable;
            r_e             <= w_e;
            {r_a, r_b, r_d, r_f, r_h} <= {w_a, w_b, w_d, w_f, w_h};
            r_blend_rule    <= w_rule_n;
            r_q             <= SLOT_TL;
            r_wcnt          <= WC_LOAD;
            r_in_ready      <= 1'b0;
            r_busy          <= 1'b1;
            r_state         <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (r_wcnt == WC_ONE) begin
            r_out_pix[PIX_W*r_q +: PIX_W] <= blend_result;
            if (r_q == SLOT_BR) begin
              r_out_valid <= 1'b1;
              r_state     <= ST_OUT;
            end else begin
              r_q          <= w_qn;
              {r_a, r_b, r_d, r_f, r_h} <= {w_a, w_b, w_d, w_f, w_h};
              r_blend_rule <= w_rule_n;
              r_wcnt       <= WC_LOAD;
            end
          end else begin
            r_wcnt <= r_wcnt - WC_ONE;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign busy          = r_busy;
  assign out_pix       = r_out_pix;
  assign blend_rule    = r_blend_rule;
  assign blend_disable = r_blend_disable;
  assign blend_e       = r_e;
  assign blend_a       = r_a;
  assign blend_b       = r_b;
  assign blend_d       = r_d;
  assign blend_f       = r_f;
  assign blend_h       = r_h;

endmodule

// File: tb/tb_hq2x_blend_sequencer.sv
// Bench for hq2x_blend_sequencer: two instances (BLEND_LATENCY 1 and 3) with a stand-in blend unit each,
// an edge-counting reference model per instance, and directed blocks with literal expectations.
module tb_hq2x_blend_sequencer;

  localparam int PW = 18;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]            in_valid, in_ready, cfg_dis, bl_dis, out_valid, out_ready, busy;
  logic [1:0][9*PW-1:0]  in_pix;
  logic [1:0][23:0]      in_rule;
  logic [1:0][5:0]       bl_rule;
  logic [1:0][PW-1:0]    bl_e, bl_a, bl_b, bl_d, bl_f, bl_h, bl_res;
  logic [1:0][4*PW-1:0]  out_pix;

  int blend_mode = 0;
  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  // Quadrant -> 3x3 index of each blend operand
  int MA[4] = '{0, 2, 6, 8};
  int MB[4] = '{1, 5, 3, 7};
  int MD[4] = '{3, 1, 7, 5};
  int MF[4] = '{5, 7, 1, 3};
  int MH[4] = '{7, 3, 5, 1};

  function automatic logic [PW-1:0] px(input logic [9*PW-1:0] p, input int i);
    return p[PW*i +: PW];
  endfunction

  // Stand-in blend: mode 0 returns A, otherwise an operand-order-sensitive mix.
  function automatic logic [PW-1:0] blend_fn(input int mode, input logic dis, input logic [5:0] rule,
                                             input logic [PW-1:0] e, a, b, d, f, h);
    if (dis) return e;
    if (mode == 0) return a;
    return (a ^ {b[PW-2:0], b[PW-1]} ^ (d + {f[PW-3:0], 2'b01}) ^ (h >> 1) ^ ~e) + {12'd0, rule};
  endfunction

  function automatic logic [4*PW-1:0] exp_block(input int mode, input logic [9*PW-1:0] p,
                                                input logic [23:0] rule, input logic dis);
    logic [4*PW-1:0] r;
    r = '0;
    for (int q = 0; q < 4; q++)
      r[PW*q +: PW] = blend_fn(mode, dis, rule[6*q +: 6], px(p, 4), px(p, MA[q]), px(p, MB[q]),
                               px(p, MD[q]), px(p, MF[q]), px(p, MH[q]));
    return r;
  endfunction

  function automatic logic [9*PW-1:0] lin_pix(input int base);
    logic [9*PW-1:0] p;
    for (int i = 0; i < 9; i++) p[PW*i +: PW] = PW'(base + i);
    return p;
  endfunction

  function automatic logic [9*PW-1:0] mix_pix(input int seed);
    logic [9*PW-1:0] p;
    for (int i = 0; i < 9; i++) p[PW*i +: PW] = PW'((seed + i) * 7919 ^ (i << 11) ^ (seed << 5));
    return p;
  endfunction

  task automatic chk(input string nm, input logic [4*PW-1:0] act, input logic [4*PW-1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  for (genvar d = 0; d < 2; d++) begin : g
    localparam int L = (d == 0) ? 1 : 3;

    hq2x_blend_sequencer #(.BLEND_LATENCY(L), .PIX_W(PW)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_valid      (in_valid[d]),
      .in_ready      (in_ready[d]),
      .in_pix        (in_pix[d]),
      .in_rule       (in_rule[d]),
      .cfg_disable   (cfg_dis[d]),
      .blend_rule    (bl_rule[d]),
      .blend_disable (bl_dis[d]),
      .blend_e       (bl_e[d]),
      .blend_a       (bl_a[d]),
      .blend_b       (bl_b[d]),
      .blend_d       (bl_d[d]),
      .blend_f       (bl_f[d]),
      .blend_h       (bl_h[d]),
      .blend_result  (bl_res[d]),
      .out_valid     (out_valid[d]),
      .out_ready     (out_ready[d]),
      .out_pix       (out_pix[d]),
      .busy          (busy[d])
    );

    logic [PW-1:0] comb;
    assign comb = blend_fn(blend_mode, bl_dis[d], bl_rule[d], bl_e[d], bl_a[d], bl_b[d],
                           bl_d[d], bl_f[d], bl_h[d]);
    if (L == 1) begin : g_comb
      assign bl_res[d] = comb;
    end else begin : g_pipe
      logic [PW-1:0] p1, p2;
      always @(posedge clk) begin
        p1 <= comb;
        p2 <= p1;
      end
      assign bl_res[d] = p2;
    end

    // Reference model: 0 idle, 1 running, 2 holding output; kc = edges since accept, plus one.
    int mst = 0, kc = 0, mmode = 0, q;
    logic [9*PW-1:0] mpix;
    logic [23:0]     mrule;
    logic            mdis;

    always @(negedge clk) begin
      if (!reset_n) begin
        mst = 0;
        kc  = 0;
      end else begin
        if (mst == 0) begin
          chk($sformatf("L%0d idle in_ready", L), 72'(in_ready[d]), 72'(1'b1));
          chk($sformatf("L%0d idle out_valid", L), 72'(out_valid[d]), 72'(1'b0));
          chk($sformatf("L%0d idle busy", L), 72'(busy[d]), 72'(1'b0));
        end else if (mst == 1) begin
          q = (kc - 1) / L;
          chk($sformatf("L%0d run in_ready", L), 72'(in_ready[d]), 72'(1'b0));
          chk($sformatf("L%0d run out_valid", L), 72'(out_valid[d]), 72'(1'b0));
          chk($sformatf("L%0d run busy", L), 72'(busy[d]), 72'(1'b1));
          chk($sformatf("L%0d q%0d rule", L, q), 72'(bl_rule[d]), 72'(mrule[6*q +: 6]));
          chk($sformatf("L%0d q%0d disable", L, q), 72'(bl_dis[d]), 72'(mdis));
          chk($sformatf("L%0d q%0d E", L, q), 72'(bl_e[d]), 72'(px(mpix, 4)));
          chk($sformatf("L%0d q%0d A", L, q), 72'(bl_a[d]), 72'(px(mpix, MA[q])));
          chk($sformatf("L%0d q%0d B", L, q), 72'(bl_b[d]), 72'(px(mpix, MB[q])));
          chk($sformatf("L%0d q%0d D", L, q), 72'(bl_d[d]), 72'(px(mpix, MD[q])));
          chk($sformatf("L%0d q%0d F", L, q), 72'(bl_f[d]), 72'(px(mpix, MF[q])));
          chk($sformatf("L%0d q%0d H", L, q), 72'(bl_h[d]), 72'(px(mpix, MH[q])));
        end else begin
          chk($sformatf("L%0d out out_valid", L), 72'(out_valid[d]), 72'(1'b1));
          chk($sformatf("L%0d out in_ready", L), 72'(in_ready[d]), 72'(1'b0));
          chk($sformatf("L%0d out busy", L), 72'(busy[d]), 72'(1'b1));
          chk($sformatf("L%0d out_pix", L), out_pix[d], exp_block(mmode, mpix, mrule, mdis));
        end
        if (mst == 0 && in_valid[d]) begin
          mst = 1; kc = 1;
          mpix = in_pix[d]; mrule = in_rule[d]; mdis = cfg_dis[d]; mmode = blend_mode;
        end else if (mst == 1) begin
          kc++;
          if (kc == 4*L + 1) mst = 2;
        end else if (mst == 2 && out_ready[d]) begin
          mst = 0;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a block and hold it until accepted; then scramble the inputs.
  task automatic send(input int d, input logic [9*PW-1:0] p, input logic [23:0] r, input logic dis);
    bit ok = 1'b0;
    in_pix[d] = p; in_rule[d] = r; cfg_dis[d] = dis; in_valid[d] = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = in_ready[d];
      tick();
    end
    in_valid[d] = 1'b0; in_pix[d] = ~p; in_rule[d] = ~r; cfg_dis[d] = ~dis;
    chk("send accepted", 72'(ok), 72'(1'b1));
  endtask

  task automatic wait_out(input int d, output int n);
    n = 0;
    while (!out_valid[d] && n < 200) begin
      tick();
      n++;
    end
  endtask

  logic [5:0]      lit_rule[4] = '{6'h3A, 6'h32, 6'h2D, 6'h3F};
  logic [PW-1:0]   lit_a[4]    = '{18'd1, 18'd3, 18'd7, 18'd9};
  logic [9*PW-1:0] p;
  int n, c0, c1, c2;

  initial begin
    in_valid = '0; in_pix = '0; in_rule = '0; cfg_dis = '0; out_ready = '0;
    tick(3);
    reset_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("reset in_ready", 72'(in_ready[d]), 72'(1'b1));
      chk("reset out_valid", 72'(out_valid[d]), 72'(1'b0));
      chk("reset busy", 72'(busy[d]), 72'(1'b0));
      chk("reset out_pix", out_pix[d], 72'(0));
      chk("reset blend ctl", 72'({bl_rule[d], bl_dis[d]}), 72'(0));
      chk("reset blend ops", 72'({bl_e[d], bl_a[d], bl_b[d]}), 72'(0));
      chk("reset blend ops2", 72'({bl_d[d], bl_f[d], bl_h[d]}), 72'(0));
    end

    // Passthrough of E
    blend_mode = 1; out_ready[0] = 1'b1;
    p = mix_pix(100); p[4*PW +: PW] = 18'h2A155;
    send(0, p, 24'h123456, 1'b1);
    wait_out(0, n);
    chk("pass latency", 72'(n), 72'(4));
    chk("pass out_pix", out_pix[0], {4{18'h2A155}});
    tick();
    chk("pass out_valid drop", 72'(out_valid[0]), 72'(1'b0));
    chk("pass in_ready back", 72'(in_ready[0]), 72'(1'b1));

    // Rotation: blend returns A
    blend_mode = 0;
    send(0, lin_pix(1), 24'hFEDCBA, 1'b0);
    for (int q = 0; q < 4; q++) begin
      chk($sformatf("rot rule q%0d", q), 72'(bl_rule[0]), 72'(lit_rule[q]));
      chk($sformatf("rot A q%0d", q), 72'(bl_a[0]), 72'(lit_a[q]));
      tick();
    end
    chk("rot out_pix", out_pix[0], {18'd9, 18'd7, 18'd3, 18'd1});
    tick();

    // Back-to-back throughput with a mixing blend
    blend_mode = 1;
    send(0, mix_pix(7), 24'h5A3C96, 1'b0);    c0 = cyc;
    send(0, mix_pix(300), 24'h0C30C3, 1'b0);  c1 = cyc;
    send(0, mix_pix(5000), 24'hF0F0F0, 1'b0); c2 = cyc;
    chk("throughput 1", 72'(c1 - c0), 72'(6));
    chk("throughput 2", 72'(c2 - c1), 72'(6));
    tick(8);

    // Three-cycle blend
    out_ready[1] = 1'b1;
    send(1, mix_pix(77), 24'h0F1E2D, 1'b0);
    wait_out(1, n);
    chk("L3 latency", 72'(n), 72'(12));
    tick(2);

    // Backpressure
    out_ready[1] = 1'b0;
    p = mix_pix(9); p[4*PW +: PW] = 18'h15AAA;
    send(1, p, 24'hABCDEF, 1'b1);
    wait_out(1, n);
    for (int i = 0; i < 10; i++) begin
      chk("bp out_pix", out_pix[1], {4{18'h15AAA}});
      chk("bp in_ready", 72'(in_ready[1]), 72'(1'b0));
      tick();
    end
    out_ready[1] = 1'b1;
    tick();
    chk("bp out_valid drop", 72'(out_valid[1]), 72'(1'b0));
    chk("bp in_ready back", 72'(in_ready[1]), 72'(1'b1));

    // Reset during quadrant 2, then a fresh block
    blend_mode = 0;
    send(0, lin_pix(1), 24'h000000, 1'b0);
    tick(2);
    reset_n = 1'b0;
    #1;
    chk("mid-reset out_valid", 72'(out_valid[0]), 72'(1'b0));
    chk("mid-reset busy", 72'(busy[0]), 72'(1'b0));
    chk("mid-reset out_pix", out_pix[0], 72'(0));
    chk("mid-reset blend A", 72'(bl_a[0]), 72'(0));
    tick(2);
    reset_n = 1'b1;
    tick();
    send(0, lin_pix(101), 24'h000000, 1'b0);
    wait_out(0, n);
    chk("post-reset latency", 72'(n), 72'(4));
    chk("post-reset out_pix", out_pix[0], {18'd109, 18'd107, 18'd103, 18'd101});
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d passed", n_pass, n_tot);
    $fatal(1);
  end

endmodule
